// File: rtl/instr_decode_queue.sv
// Decodes 32-bit instructions to control-unit start states and buffers them in a small FIFO.
// Define DECODE_COND_EN to evaluate the ARM condition field against Flags (failures emit NOP_STATE).
module instr_decode_queue #(
    parameter int unsigned STATE_W       = 6,
    parameter int unsigned DEPTH         = 2,
    parameter int unsigned NOP_STATE     = 1,
    parameter int unsigned ILLEGAL_STATE = 63,
    parameter int unsigned CNT_W         = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [31:0]        In,
    input  logic               In_valid,
    output logic               In_ready,
    input  logic [3:0]         Flags,
    output logic [STATE_W-1:0] Out,
    output logic               Out_illegal,
    output logic               Out_valid,
    input  logic               Out_ready,
    output logic [CNT_W-1:0]   Illegal_cnt
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned COUNT_W = $clog2(DEPTH + 1);
    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(DEPTH);

    typedef logic [STATE_W:0] entry_t;

    entry_t               mem_q [DEPTH];
    entry_t               mem_d [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]     ill_cnt_q, ill_cnt_d;

    logic [STATE_W-1:0]   tbl_state;
    logic                 tbl_legal;
    logic                 cond_pass;
    entry_t               new_entry;
    logic                 push, pop;

    always_comb begin
        tbl_state = '0;
        tbl_legal = 1'b0;
        unique case (In[27:25])
            3'b000: begin
                if (In[24:21] == 4'b0100) begin
                    tbl_legal = 1'b1;
                    tbl_state = In[4] ? STATE_W'(10) : STATE_W'(11);
                end
            end
            3'b001: begin
                tbl_legal = 1'b1;
                case (In[24:21])
                    4'b0100: tbl_state = STATE_W'(12);
                    4'b1010: tbl_state = STATE_W'(13);
                    4'b1101: tbl_state = STATE_W'(14);
                    4'b0010: tbl_state = STATE_W'(15);
                    default: tbl_legal = 1'b0;
                endcase
            end
            3'b010: begin
                tbl_legal = 1'b1;
                case ({In[24], In[20]})
                    2'b00:   tbl_state = STATE_W'(20);
                    2'b01:   tbl_state = STATE_W'(25);
                    2'b10:   tbl_state = STATE_W'(21);
                    default: tbl_state = STATE_W'(26);
                endcase
            end
            3'b101: begin
                tbl_legal = 1'b1;
                tbl_state = In[24] ? STATE_W'(31) : STATE_W'(30);
            end
            default: begin
                tbl_legal = 1'b0;
            end
        endcase
    end

`ifdef DECODE_COND_EN
    logic n_f, z_f, c_f, v_f;
    assign {n_f, z_f, c_f, v_f} = Flags;

    always_comb begin
        cond_pass = 1'b0;
        case (In[31:28])
            4'b0000: cond_pass = z_f;
            4'b0001: cond_pass = !z_f;
            4'b0010: cond_pass = c_f;
            4'b0011: cond_pass = !c_f;
            4'b0100: cond_pass = n_f;
            4'b0101: cond_pass = !n_f;
            4'b0110: cond_pass = v_f;
            4'b0111: cond_pass = !v_f;
            4'b1000: cond_pass = c_f && !z_f;
            4'b1001: cond_pass = !c_f || z_f;
            4'b1010: cond_pass = (n_f == v_f);
            4'b1011: cond_pass = (n_f != v_f);
            4'b1100: cond_pass = !z_f && (n_f == v_f);
            4'b1101: cond_pass = z_f || (n_f != v_f);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end
`else
    logic unused_cond;
    assign unused_cond = ^{In[31:28], Flags};
    assign cond_pass   = 1'b1;
`endif

    logic unused_bits;
    assign unused_bits = ^{In[19:5], In[3:0]};

    // Illegal takes priority over a failed condition.
    always_comb begin
        if (!tbl_legal)
            new_entry = {1'b1, STATE_W'(ILLEGAL_STATE)};
        else if (!cond_pass)
            new_entry = {1'b0, STATE_W'(NOP_STATE)};
        else
            new_entry = {1'b0, tbl_state};
    end

    assign push = In_valid && In_ready;
    assign pop  = Out_valid && Out_ready;

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ill_cnt_d = ill_cnt_q;

        if (push) begin
            mem_d[wr_ptr_q] = new_entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
            if (new_entry[STATE_W] && (ill_cnt_q != '1))
                ill_cnt_d = ill_cnt_q + 1'b1;
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ill_cnt_q <= '0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    assign Out         = mem_q[rd_ptr_q][STATE_W-1:0];
    assign Out_illegal = mem_q[rd_ptr_q][STATE_W];
    assign Out_valid   = (count_q != '0);
    assign In_ready    = (count_q < FULL_COUNT);
    assign Illegal_cnt = ill_cnt_q;

endmodule

// File: tb/tb_instr_decode_queue.sv
// Table-driven bench for instr_decode_queue plus directed backpressure and reset sequences.
module tb_instr_decode_queue;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] In;
    logic        In_valid;
    logic        In_ready;
    logic [3:0]  Flags;
    logic [5:0]  Out;
    logic        Out_illegal;
    logic        Out_valid;
    logic        Out_ready;
    logic [7:0]  Illegal_cnt;

    logic        In_ready2;
    logic [5:0]  Out2;
    logic        Out_illegal2;
    logic        Out_valid2;
    logic [1:0]  Illegal_cnt2;

`ifdef DECODE_COND_EN
    localparam bit COND_EN = 1'b1;
`else
    localparam bit COND_EN = 1'b0;
`endif

    instr_decode_queue #(
        .STATE_W(6), .DEPTH(2), .NOP_STATE(1), .ILLEGAL_STATE(63), .CNT_W(8)
    ) dut (
        .Clk(Clk), .Reset(Reset), .In(In), .In_valid(In_valid), .In_ready(In_ready),
        .Flags(Flags), .Out(Out), .Out_illegal(Out_illegal), .Out_valid(Out_valid),
        .Out_ready(Out_ready), .Illegal_cnt(Illegal_cnt)
    );

    // Narrow-counter copy fed the same stimulus, used for saturation.
    instr_decode_queue #(
        .STATE_W(6), .DEPTH(2), .NOP_STATE(1), .ILLEGAL_STATE(63), .CNT_W(2)
    ) dut_sat (
        .Clk(Clk), .Reset(Reset), .In(In), .In_valid(In_valid), .In_ready(In_ready2),
        .Flags(Flags), .Out(Out2), .Out_illegal(Out_illegal2), .Out_valid(Out_valid2),
        .Out_ready(Out_ready), .Illegal_cnt(Illegal_cnt2)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [3:0]  flags;
        logic [5:0]  st;
        logic        ill;
        logic        cf;
    } vec_t;

    vec_t vecs[32];

    initial begin
        int exp_cnt;
        logic [5:0] exp_st;

        vecs[0]  = '{32'hE0810002, 4'h0, 6'd11, 1'b0, 1'b0};
        vecs[1]  = '{32'hE0810012, 4'h0, 6'd10, 1'b0, 1'b0};
        vecs[2]  = '{32'h0A000000, 4'h0, 6'd30, 1'b0, 1'b1};
        vecs[3]  = '{32'h0A000000, 4'h4, 6'd30, 1'b0, 1'b0};
        vecs[4]  = '{32'hE6000000, 4'h0, 6'd63, 1'b1, 1'b0};
        vecs[5]  = '{32'hE3A00000, 4'h0, 6'd14, 1'b0, 1'b0};
        vecs[6]  = '{32'hE2800000, 4'h0, 6'd12, 1'b0, 1'b0};
        vecs[7]  = '{32'hE3500000, 4'h0, 6'd13, 1'b0, 1'b0};
        vecs[8]  = '{32'hE2400000, 4'h0, 6'd15, 1'b0, 1'b0};
        vecs[9]  = '{32'hE4000000, 4'h0, 6'd20, 1'b0, 1'b0};
        vecs[10] = '{32'hE4100000, 4'h0, 6'd25, 1'b0, 1'b0};
        vecs[11] = '{32'hE5000000, 4'h0, 6'd21, 1'b0, 1'b0};
        vecs[12] = '{32'hE5900000, 4'h0, 6'd26, 1'b0, 1'b0};
        vecs[13] = '{32'hEB000000, 4'h0, 6'd31, 1'b0, 1'b0};
        vecs[14] = '{32'h1B000000, 4'h4, 6'd31, 1'b0, 1'b1};
        vecs[15] = '{32'hFA000000, 4'hF, 6'd30, 1'b0, 1'b1};
        vecs[16] = '{32'hE0A10002, 4'h0, 6'd63, 1'b1, 1'b0};
        vecs[17] = '{32'hF6000000, 4'h0, 6'd63, 1'b1, 1'b0};
        vecs[18] = '{32'hE3000000, 4'h0, 6'd63, 1'b1, 1'b0};
        vecs[19] = '{32'hAA000000, 4'h9, 6'd30, 1'b0, 1'b0};
        vecs[20] = '{32'hBA000000, 4'h9, 6'd30, 1'b0, 1'b1};
        vecs[21] = '{32'h8A000000, 4'h2, 6'd30, 1'b0, 1'b0};
        vecs[22] = '{32'hE8000000, 4'h0, 6'd63, 1'b1, 1'b0};
        vecs[23] = '{32'h9A000000, 4'h2, 6'd30, 1'b0, 1'b1};
        vecs[24] = '{32'hCA000000, 4'h0, 6'd30, 1'b0, 1'b0};
        vecs[25] = '{32'h3A000000, 4'h2, 6'd30, 1'b0, 1'b1};
        vecs[26] = '{32'h6A000000, 4'h1, 6'd30, 1'b0, 1'b0};
        vecs[27] = '{32'h7A000000, 4'h1, 6'd30, 1'b0, 1'b1};
        vecs[28] = '{32'h4A000000, 4'h8, 6'd30, 1'b0, 1'b0};
        vecs[29] = '{32'hDA000000, 4'h8, 6'd30, 1'b0, 1'b0};
        vecs[30] = '{32'h2A000000, 4'h0, 6'd30, 1'b0, 1'b1};
        vecs[31] = '{32'h5A000000, 4'h8, 6'd30, 1'b0, 1'b1};

        Reset = 1'b1; In = '0; In_valid = 1'b0; Flags = '0; Out_ready = 1'b0;
        tick(); tick();
        check("rst_out", Out, 0);
        check("rst_illegal", Out_illegal, 0);
        check("rst_valid", Out_valid, 0);
        check("rst_cnt", Illegal_cnt, 0);
        Reset = 1'b0;
        tick();
        check("rst_in_ready", In_ready, 1);

        exp_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            In = vecs[i].ins; Flags = vecs[i].flags; In_valid = 1'b1; Out_ready = 1'b0;
            tick();
            In_valid = 1'b0;
            if (vecs[i].ill) begin
                exp_st = 6'd63;
                exp_cnt++;
            end else if (COND_EN && vecs[i].cf) begin
                exp_st = 6'd1;
            end else begin
                exp_st = vecs[i].st;
            end
            check($sformatf("vec%0d_out", i), Out, exp_st);
            check($sformatf("vec%0d_illegal", i), Out_illegal, vecs[i].ill);
            check($sformatf("vec%0d_valid", i), Out_valid, 1);
            check($sformatf("vec%0d_cnt", i), Illegal_cnt, exp_cnt);
            check($sformatf("vec%0d_cnt_sat", i), Illegal_cnt2, (exp_cnt > 3) ? 3 : exp_cnt);
            Out_ready = 1'b1;
            tick();
            Out_ready = 1'b0;
            check($sformatf("vec%0d_drained", i), Out_valid, 0);
        end

        // Backpressure with DEPTH=2, followed by push+pop at count 1.
        In_valid = 1'b1; Out_ready = 1'b0; Flags = 4'h0;
        In = 32'hE3A00000; tick();
        check("bp_ready_1", In_ready, 1);
        check("bp_head_1", Out, 14);
        In = 32'hE2800000; tick();
        check("bp_ready_full", In_ready, 0);
        check("bp_head_2", Out, 14);
        In = 32'hE3500000; tick();
        check("bp_stall_ready", In_ready, 0);
        check("bp_stall_head", Out, 14);
        check("bp_stall_valid", Out_valid, 1);
        Out_ready = 1'b1; tick();
        check("bp_pop1_head", Out, 12);
        check("bp_pop1_ready", In_ready, 1);
        tick();
        check("bp_swap_head", Out, 13);
        check("bp_swap_valid", Out_valid, 1);
        check("bp_swap_ready", In_ready, 1);
        In_valid = 1'b0; tick();
        check("bp_empty", Out_valid, 0);

        // Explicit simultaneous push and pop at count 1.
        Out_ready = 1'b0; In_valid = 1'b1; In = 32'hE0810002; tick();
        check("pp_head_a", Out, 11);
        In = 32'hE0810012; Out_ready = 1'b1; tick();
        check("pp_head_b", Out, 10);
        check("pp_valid", Out_valid, 1);
        check("pp_ready", In_ready, 1);
        In_valid = 1'b0; tick();
        check("pp_empty", Out_valid, 0);
        Out_ready = 1'b0;

        // Reset asserted mid-operation with two illegal entries queued.
        Reset = 1'b1; tick(); Reset = 1'b0; tick();
        In_valid = 1'b1; In = 32'hE6000000; tick();
        In = 32'hE8000000; tick();
        In_valid = 1'b0;
        check("mr_cnt_before", Illegal_cnt, 2);
        check("mr_full", In_ready, 0);
        #2 Reset = 1'b1;
        #1;
        check("mr_async_valid", Out_valid, 0);
        check("mr_async_cnt", Illegal_cnt, 0);
        check("mr_async_out", Out, 0);
        tick();
        Reset = 1'b0;
        tick();
        check("mr_in_ready", In_ready, 1);
        check("mr_valid", Out_valid, 0);
        In_valid = 1'b1; In = 32'hE2800000; tick();
        In_valid = 1'b0;
        check("mr_next_out", Out, 12);
        check("mr_next_illegal", Out_illegal, 0);
        check("mr_next_valid", Out_valid, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_decode_queue.md
# instr_decode_queue

Registered, parametrised successor to the combinational instruction-to-state encoder. It sits between instruction fetch and the control-unit sequencer. It accepts 32-bit instructions over a valid/ready handshake and decodes each into a control-unit start-state number, optionally evaluating the condition field against the NZCV flags. Decoded entries are buffered in a small FIFO so fetch and the sequencer can stall independently.

## Interface
- STATE_W, 6: width of state numbers; must be ≥ 6.
- DEPTH, 2: output FIFO entries; power of two, ≥ 2.
- NOP_STATE, 1: state emitted when the condition fails.
- ILLEGAL_STATE, 63: state emitted for undecodable instructions.
- CNT_W, 8: width of the illegal-instruction counter.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- In  in  32  instruction word.
- In_valid  in  1  In is valid.
- In_ready  out  1  block can accept In.
- Flags  in  4  {N,Z,C,V}, sampled in the cycle In is accepted.
- Out  out  STATE_W  decoded state at FIFO head.
- Out_illegal  out  1  head entry was undecodable.
- Out_valid  out  1  FIFO non-empty.
- Out_ready  in  1  sequencer consumes the head.
- Illegal_cnt  out  CNT_W  saturating count of illegal instructions accepted.

## Operation
- Accept when In_valid && In_ready. Pop when Out_valid && Out_ready.
- Decode table, by In[27:25]:
  - 000, In[24:21]=0100: In[4]=0 → 11; In[4]=1 → 10.
  - 001: In[24:21]=0100 → 12; 1010 → 13; 1101 → 14; 0010 → 15.
  - 010: In[24]=0 gives In[20]=0 → 20 and In[20]=1 → 25. In[24]=1 gives In[20]=0 → 21 and In[20]=1 → 26.
  - 101: In[24]=0 → 30; In[24]=1 → 31.
  - Any other pattern → ILLEGAL_STATE, with Out_illegal=1 for that entry.
- Condition evaluation uses In[31:28] with the standard ARM encodings 0000 EQ through 1110 AL. Code 1111 counts as a failed condition.
- Priority: an illegal instruction gives ILLEGAL_STATE regardless of its condition. A legal instruction whose condition fails gives NOP_STATE with Out_illegal=0.
- Illegal_cnt increments once per accepted illegal instruction and saturates at all-ones.
- FIFO:
  - Count ranges 0..DEPTH; pointers wrap modulo DEPTH.
  - In_ready = (count < DEPTH); there is no pass-through when full.
  - Simultaneous push and pop leaves the count unchanged; both operations take effect.

## Timing
- Reset values:
  - Out=0, Out_illegal=0, Out_valid=0, Illegal_cnt=0.
  - FIFO is emptied; In_ready=1 once Reset deasserts.
- Latency: an instruction accepted at edge k appears at Out with Out_valid=1 after edge k, when the FIFO was empty. There is no combinational path from In to Out.
- Out and Out_illegal hold stable while Out_valid && !Out_ready.
- In_ready depends only on the registered count, never combinationally on Out_ready.
- Reset asserted mid-operation immediately empties the FIFO and clears the counter. In-flight entries are dropped.

## Configuration
- DECODE_COND_EN defined: the condition is evaluated as described above, and failing instructions emit NOP_STATE.
- DECODE_COND_EN undefined: In[31:28] and Flags are ignored and every legal instruction emits its table state. Illegal handling is unchanged.

## Test plan
- Reset, then push In=0xE0810002 → next cycle Out=11, Out_valid=1, Out_illegal=0. Push 0xE0810012 → Out=10.
- With DECODE_COND_EN, push 0x0A000000 (BEQ):
  - With Flags=4'b0000, Out=1.
  - With Flags=4'b0100, Out=30.
  - Without the macro, both cases give Out=30.
- Push 0xE6000000 → Out=63, Out_illegal=1, Illegal_cnt=1. With CNT_W=2, push 5 illegal instructions → Illegal_cnt=3.
- DEPTH=2, hold Out_ready=0, push 0xE3A00000, 0xE2800000, 0xE3500000:
  - In_ready goes 0 after the 2nd accept; the third is stalled.
  - Raise Out_ready: pops return 14 then 12, then 13 is accepted and returned.
- Simultaneous push and pop at count=1 → count stays 1 and order is preserved.
- Assert Reset with 2 entries queued and Illegal_cnt=2 → Out_valid=0, Illegal_cnt=0 and In_ready=1 after release; the next push decodes normally.
